// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding,
// the state type and the default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/shift_add_mult_if.sv
// Request/response bundle between a controller (master) and the multiplier (slave).
interface shift_add_mult_if #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) ();
  import mult_pkg::*;

  // start is only sampled while the multiplier is idle. a and b are captured on
  // that same accepting edge. busy stays high for WIDTH cycles, then done pulses
  // for one cycle. product is valid from the done cycle and holds until the next
  // completion or reset. state mirrors the internal FSM for observation.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  state_t               state;

  modport master (
    output start, a, b,
    input  busy, done, product, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, state
  );

endinterface

// File: rtl/shift_add_mult_ripple_add.sv
// Purely combinational WIDTH-bit ripple-carry adder, same port order as the 4-bit adder.
module ripple_add #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per cycle,
// WIDTH cycles per multiply, registered and held 2*WIDTH-bit product.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  shift_add_mult_if.slave    bus
);

  localparam int               CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  state_t               state_q,   state_d;
  logic [WIDTH-1:0]     m_q,       m_d;
  logic [WIDTH-1:0]     acc_q,     acc_d;
  logic [WIDTH-1:0]     q_q,       q_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     add_s;
  logic                 add_c;
  logic [2*WIDTH-1:0]   shifted;

  assign addend = q_q[0] ? m_q : '0;

  ripple_add #(.WIDTH(WIDTH)) u_add (
    .sum  (add_s),
    .cout (add_c),
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0)
  );

  // Carry becomes the MSB of the new upper half, so the result never overflows.
  assign shifted = {add_c, add_s, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + CNT_ONE;
        if (cnt_q == LAST) begin
          product_d = shifted;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == ST_CALC);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: WIDTH=4 and WIDTH=8 instances on one clock.
module tb_shift_add_mult;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_add_mult_if #(.WIDTH(4)) bus4 ();
  shift_add_mult_if #(.WIDTH(8)) bus8 ();

  shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_done_cyc;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w8) begin
      bus8.start = s; bus8.a = a; bus8.b = b;
    end else begin
      bus4.start = s; bus4.a = a[3:0]; bus4.b = b[3:0];
    end
  endtask

  function automatic logic get_done(input bit w8);
    return w8 ? bus8.done : bus4.done;
  endfunction

  function automatic logic get_busy(input bit w8);
    return w8 ? bus8.busy : bus4.busy;
  endfunction

  function automatic logic [15:0] get_product(input bit w8);
    return w8 ? bus8.product : {8'd0, bus4.product};
  endfunction

  // Issue one multiply in the next cycle; return at the negedge of the done cycle.
  task automatic run(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit hold,
                     output logic [15:0] p, output int lat, output int busy_n);
    logic [15:0] exp;
    @(negedge clk);
    drive(w8, 1'b1, a, b);
    exp_q.push_back(16'(a) * 16'(b));
    lat    = 0;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (hold) drive(w8, 1'b1, 8'd1, 8'd1);
      else      drive(w8, 1'b0, 8'hxx, 8'hxx);
      if (get_busy(w8)) busy_n++;
      if (get_done(w8)) begin
        lat = n;
        break;
      end
    end
    drive(w8, 1'b0, a, b);
    p = get_product(w8);
    last_done_cyc = cyc;
    exp = exp_q.pop_front();
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    else          check(w8 ? "sb_product8" : "sb_product4", p, exp);
  endtask

  task automatic post_done(input bit w8, input logic [15:0] expp);
    @(negedge clk);
    check("post_done_low", get_done(w8), 1'b0);
    check("post_busy_low", get_busy(w8), 1'b0);
    check("product_held", get_product(w8), expp);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [15:0] p;
    int          lat, busy_n, ndone, first_done;

    vecs.push_back('{8'd15, 8'd15, 16'd225});
    vecs.push_back('{8'd13, 8'd11, 16'd143});
    vecs.push_back('{8'd0,  8'd9,  16'd0});
    vecs.push_back('{8'd7,  8'd6,  16'd42});
    vecs.push_back('{8'd3,  8'd5,  16'd15});
    vecs.push_back('{8'd15, 8'd1,  16'd15});
    vecs.push_back('{8'd1,  8'd0,  16'd0});
    vecs.push_back('{8'd8,  8'd14, 16'd112});

    // Reset then idle
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", bus4.busy, 1'b0);
      check("rst_done", bus4.done, 1'b0);
      check("rst_product", bus4.product, 8'd0);
      check("rst_state", bus4.state, ST_IDLE);
      check("rst_product8", bus8.product, 16'd0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", bus4.busy, 1'b0);
      check("idle_done", bus4.done, 1'b0);
    end

    // Table-driven vectors, WIDTH=4
    foreach (vecs[i]) begin
      run(1'b0, vecs[i].a, vecs[i].b, 1'b0, p, lat, busy_n);
      check("tbl_product", p, vecs[i].p);
      check("tbl_latency", lat, 5);
      check("tbl_busy_cycles", busy_n, 4);
      post_done(1'b0, vecs[i].p);
    end

    // Back-to-back: second start in the first IDLE cycle after done
    run(1'b0, 8'd13, 8'd11, 1'b0, p, lat, busy_n);
    check("b2b_first", p, 143);
    first_done = last_done_cyc;
    run(1'b0, 8'd0, 8'd9, 1'b0, p, lat, busy_n);
    check("b2b_second", p, 0);
    check("b2b_spacing", last_done_cyc - first_done, 6);

    // start held during CALC and DONE must be ignored
    run(1'b0, 8'd7, 8'd6, 1'b1, p, lat, busy_n);
    check("ignore_start_product", p, 42);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.done) ndone++;
    end
    check("ignore_start_no_extra_done", ndone, 0);
    check("ignore_start_held", bus4.product, 42);

    // Reset in the 2nd CALC cycle discards the operation
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd9, 8'd9);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    check("mid_busy_before_rst", bus4.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", bus4.busy, 1'b0);
    check("mid_rst_product", bus4.product, 8'd0);
    check("mid_rst_state", bus4.state, ST_IDLE);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    run(1'b0, 8'd3, 8'd5, 1'b0, p, lat, busy_n);
    check("after_rst_product", p, 15);

    // Exhaustive WIDTH=4
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run(1'b0, 8'(x), 8'(y), 1'b0, p, lat, busy_n);
        if (lat != 5) check("exh_latency", lat, 5);
      end
    end

    // Random WIDTH=8
    for (int i = 0; i < 200; i++) begin
      run(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, p, lat, busy_n);
      if (lat != 9 || busy_n != 8) begin
        check("rnd8_latency", lat, 9);
        check("rnd8_busy_cycles", busy_n, 8);
      end
    end
    run(1'b1, 8'd255, 8'd255, 1'b0, p, lat, busy_n);
    check("max8_product", p, 16'd65025);
    check("max8_latency", lat, 9);
    post_done(1'b1, 16'd65025);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add unsigned multiplier built directly on top of the team's ripple adder: each cycle it conditionally adds the multiplicand into a running partial product and shifts one multiplier bit out. It consumes adder sum/carry as its datapath core and presents a start/busy/done handshake to the surrounding control. A WIDTH x WIDTH multiply completes in WIDTH cycles with a registered, held 2*WIDTH-bit result.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, unsigned; sampled at the accepting edge
- b  input  WIDTH  multiplier, unsigned; sampled at the accepting edge
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse; high only in DONE
- product  output  2*WIDTH  registered result a*b; held until the next completion or reset

## Operation
- Registers: m (WIDTH, multiplicand), acc (WIDTH, upper partial product), q (WIDTH, multiplier / lower product), cnt ($clog2(WIDTH)+1 bits), state, product.
- FSM states: IDLE, CALC, DONE.
- IDLE: if start=1 at an edge, load m<=a, q<=b, acc<=0, cnt<=0, go to CALC. Otherwise stay.
- CALC, per edge: {c,s} = acc + (q[0] ? m : 0) with cin=0; then {acc,q} <= {c, s, q[WIDTH-1:1]}; cnt<=cnt+1. The edge where cnt==WIDTH-1 also loads product <= {c, s, q[WIDTH-1:1]} and moves to DONE.
- DONE: done=1 for exactly one cycle; next edge unconditionally returns to IDLE.
- Arithmetic: all unsigned; adder carry c is the MSB of the shifted-in word, so no overflow is possible (max (2^W-1)^2 fits 2*W bits).
- start in CALC or DONE: ignored, no effect on operands or result; a/b changes outside the accepting edge: ignored.
- busy and done are never high in the same cycle; both are decoded from state, not registered separately.
- rst=1 at any edge (including mid-CALC): state<=IDLE, acc/q/m/cnt<=0, product<=0; the in-flight operation is discarded and no done is produced. rst has priority over start.

## Timing
- Reset values: busy=0, done=0, product=0.
- start accepted at edge k -> busy high in cycles k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH (WIDTH cycles latency; 4 for default).
- product updates at the same edge that asserts done and is stable from that cycle onward.
- Earliest next acceptance: the edge ending the cycle after done (IDLE cycle); sustained throughput one result per WIDTH+2 cycles.
- start held high continuously: one multiply per WIDTH+2 cycles, operands sampled at each acceptance edge.

## Structure
- Shared package mult_pkg: state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2; state typedef; default WIDTH constant.
- One sub-module: ripple_add #(WIDTH) — purely combinational, ports sum, cout, a, b, cin (same port order as the team's 4-bit adder), instantiated once with cin tied 0. All sequencing stays in shift_add_mult.

## Test plan
- Reset then idle: rst high 2 cycles, start=0 -> busy=0, done=0, product=0 throughout.
- a=15, b=15, start 1 cycle -> busy 4 cycles, done pulse in cycle 5 after acceptance, product=225 (8'hE1), held after done falls.
- a=13, b=11 then a=0, b=9 back-to-back (start in first IDLE cycle after done) -> products 143 then 0; second done exactly 6 cycles after the first.
- a=7, b=6 accepted, then start=1 with a=1, b=1 during CALC and during DONE -> product=42, exactly one done pulse.
- a=9, b=9 accepted, rst at 2nd CALC cycle -> busy=0 and product=0 next cycle, no done; new start a=3, b=5 -> product=15.
- Exhaustive: all 256 (a,b) pairs, WIDTH=4, each checked against a*b at done; repeat 200 random pairs with WIDTH=8.
